// File: rtl/wb_port_scheduler_pkg.sv
// Shared constants for the integer write-back path.
package wb_port_scheduler_pkg;

  // Requester slot assignment on the write-back arbiter
  localparam int unsigned REQ_ALU    = 0;
  localparam int unsigned REQ_MEM    = 1;
  localparam int unsigned REQ_FPU    = 2;
  localparam int unsigned NUM_WB_REQ = 3;

  // Integer datapath geometry
  localparam int unsigned XLEN       = 64;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ReqAlu = 2'd0,
    ReqMem = 2'd1,
    ReqFpu = 2'd2
  } req_id_e;

endpackage

// File: rtl/wb_port_scheduler_if.sv
// Write-back requester bus, register file write port and scoreboard view.
interface wb_port_scheduler_if
  import wb_port_scheduler_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = XLEN,
  parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
  parameter int unsigned NUM_REQ    = NUM_WB_REQ
);

  logic [NUM_REQ-1:0]            req_Valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_Addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_Data;
  logic [NUM_REQ-1:0]            req_Grant;

  logic                          rf_write_En;
  logic [ADDR_WIDTH-1:0]         rf_writeAddr;
  logic [DATA_WIDTH-1:0]         rf_data_in;

  logic                          issue_En;
  logic [ADDR_WIDTH-1:0]         issue_Addr;
  logic [(1<<ADDR_WIDTH)-1:0]    busy_Vec;

  // Scheduler side
  modport slave (
    input  req_Valid, req_Addr, req_Data, issue_En, issue_Addr,
    output req_Grant, rf_write_En, rf_writeAddr, rf_data_in, busy_Vec
  );

  // Requesters, decode and register file side
  modport master (
    output req_Valid, req_Addr, req_Data, issue_En, issue_Addr,
    input  req_Grant, rf_write_En, rf_writeAddr, rf_data_in, busy_Vec
  );

endinterface

// File: rtl/wb_port_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches from rr_ptr upward, pointer moves past each winner.
module wb_port_scheduler_rr_arbiter #(
  parameter  int unsigned N    = 3,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [N-1:0]    valid,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] idx
);

  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [N-1:0]    grant_raw;
  logic [IdxW-1:0] idx_raw;
  logic            found;

  // Pick the first valid requester at distance k from rr_ptr, smallest k wins
  always_comb begin
    grant_raw = '0;
    idx_raw   = '0;
    found     = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && valid[i] && ((32'(rr_ptr_q) + k) % N == i)) begin
          found        = 1'b1;
          grant_raw[i] = 1'b1;
          idx_raw      = IdxW'(i);
        end
      end
    end
  end

  // Advance pointer past the winner; hold when nothing is granted
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (found) begin
      rr_ptr_d = (32'(idx_raw) + 1 == N) ? '0 : idx_raw + IdxW'(1);
    end
  end

  // Pointer state
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Grant is suppressed while reset is held
  always_comb begin
    grant = Rst ? '0 : grant_raw;
    idx   = idx_raw;
  end

endmodule

// File: rtl/wb_port_scheduler.sv
// Shares the integer register file write port between write-back requesters
// and tracks pending destination registers for decode stall decisions.
module wb_port_scheduler
  import wb_port_scheduler_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = XLEN,
  parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
  parameter int unsigned NUM_REQ    = NUM_WB_REQ
) (
  input logic               Clk,
  input logic               Rst,
  wb_port_scheduler_if.slave bus
);

  localparam int unsigned IdxW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NumRegs = 1 << ADDR_WIDTH;

  logic [NUM_REQ-1:0]    gnt;
  logic [IdxW-1:0]       gnt_idx;
  logic                  gnt_any;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [NumRegs-1:0]    busy_q, busy_d;

  wb_port_scheduler_rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .Clk   (Clk),
    .Rst   (Rst),
    .valid (bus.req_Valid),
    .grant (gnt),
    .idx   (gnt_idx)
  );

  assign gnt_any       = |gnt;
  assign bus.req_Grant = gnt;

  // Select the granted requester's address and data
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IdxW'(i)) begin
        sel_addr = bus.req_Addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = bus.req_Data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Output stage next state; x0 writes take the slot but never enable the write
  always_comb begin
    wr_en_d   = gnt_any && (sel_addr != '0);
    wr_addr_d = gnt_any ? sel_addr : wr_addr_q;
    wr_data_d = gnt_any ? sel_data : wr_data_q;
  end

  // Scoreboard next state; a new issue beats a commit to the same register
  always_comb begin
    busy_d = busy_q;
    for (int unsigned r = 1; r < NumRegs; r++) begin
      if (bus.issue_En && bus.issue_Addr == ADDR_WIDTH'(r)) begin
        busy_d[r] = 1'b1;
      end else if (wr_en_q && wr_addr_q == ADDR_WIDTH'(r)) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  // Output register and scoreboard state
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.rf_write_En  = wr_en_q;
  assign bus.rf_writeAddr = wr_addr_q;
  assign bus.rf_data_in   = wr_data_q;
  assign bus.busy_Vec     = busy_q;

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Directed bench with a behavioural arbiter/scoreboard model and expected-write queue.
module tb_wb_port_scheduler;
  import wb_port_scheduler_pkg::*;

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [63:0] data;
  } wr_t;

  logic Clk = 1'b0;
  logic Rst = 1'b0;

  wb_port_scheduler_if bus ();

  wb_port_scheduler dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  wr_t         exp_q[$];
  logic [31:0] m_busy;
  int          m_ptr;
  wr_t         m_rf;
  logic [4:0]  m_addr[3];
  logic [63:0] m_data[3];
  int          g;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decode must never issue to a register that still has a write pending
  always @(posedge Clk) begin
    if (!Rst && bus.issue_En && bus.issue_Addr != 5'd0) begin
      assert (bus.busy_Vec[bus.issue_Addr] !== 1'b1) else begin
        n_fail++;
        $error("FAIL waw_issue reg=%0d observed=busy expected=idle", bus.issue_Addr);
      end
    end
  end

  // One cycle: drive at negedge, check grant, push expectation, check after edge
  task automatic step(input logic [2:0] v, input logic ie, input logic [4:0] ia,
                      output int gw);
    logic [2:0]  eg;
    wr_t         nw;
    wr_t         got;
    logic [31:0] nb;
    bus.req_Valid = v;
    for (int i = 0; i < 3; i++) begin
      bus.req_Addr[i*5 +: 5]   = m_addr[i];
      bus.req_Data[i*64 +: 64] = m_data[i];
    end
    bus.issue_En   = ie;
    bus.issue_Addr = ia;
    #1;
    gw = -1;
    for (int k = 0; k < 3; k++) begin
      int c;
      c = (m_ptr + k) % 3;
      if (gw < 0 && v[c[1:0]]) gw = c;
    end
    eg = '0;
    if (gw >= 0) eg[gw[1:0]] = 1'b1;
    chk("grant", 64'(bus.req_Grant), 64'(eg));
    nw    = m_rf;
    nw.en = 1'b0;
    if (gw >= 0) begin
      nw.addr = m_addr[gw];
      nw.data = m_data[gw];
      nw.en   = (m_addr[gw] != 5'd0);
      m_ptr   = (gw + 1) % 3;
    end
    exp_q.push_back(nw);
    nb = m_busy;
    for (int r = 1; r < 32; r++) begin
      if (ie && ia == 5'(r)) nb[r] = 1'b1;
      else if (m_rf.en && m_rf.addr == 5'(r)) nb[r] = 1'b0;
    end
    @(posedge Clk);
    #1;
    got    = exp_q.pop_front();
    m_rf   = got;
    m_busy = nb;
    chk("rf_write_En", 64'(bus.rf_write_En), 64'(got.en));
    chk("rf_writeAddr", 64'(bus.rf_writeAddr), 64'(got.addr));
    chk("rf_data_in", bus.rf_data_in, got.data);
    chk("busy_Vec", 64'(bus.busy_Vec), 64'(m_busy));
    @(negedge Clk);
  endtask

  // Mid-cycle async reset with all requests valid; outputs must clear at once
  task automatic do_reset();
    bus.req_Valid = 3'b111;
    #2 Rst = 1'b1;
    #1;
    chk("rst_grant", 64'(bus.req_Grant), 64'd0);
    chk("rst_rf_en", 64'(bus.rf_write_En), 64'd0);
    chk("rst_rf_addr", 64'(bus.rf_writeAddr), 64'd0);
    chk("rst_rf_data", bus.rf_data_in, 64'd0);
    chk("rst_busy", 64'(bus.busy_Vec), 64'd0);
    m_ptr  = 0;
    m_rf   = '0;
    m_busy = '0;
    exp_q.delete();
    @(negedge Clk);
    Rst           = 1'b0;
    bus.req_Valid = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_Valid  = '0;
    bus.req_Addr   = '0;
    bus.req_Data   = '0;
    bus.issue_En   = 1'b0;
    bus.issue_Addr = '0;
    for (int i = 0; i < 3; i++) begin
      m_addr[i] = '0;
      m_data[i] = '0;
    end

    // Reset then idle
    do_reset();
    for (int i = 0; i < 10; i++) step(3'b000, 1'b0, 5'd0, g);

    // Single write: issue r5, then ALU writes it; busy clears one edge after the write
    step(3'b000, 1'b1, 5'd5, g);
    m_addr[REQ_ALU] = 5'd5;
    m_data[REQ_ALU] = 64'hDEAD_BEEF;
    step(3'b001, 1'b0, 5'd0, g);
    step(3'b000, 1'b0, 5'd0, g);

    // Async reset with non-zero output registers
    do_reset();

    // Contention: all valid continuously, new data after each grant
    m_addr[REQ_ALU] = 5'd1;  m_data[REQ_ALU] = 64'h1111;
    m_addr[REQ_MEM] = 5'd2;  m_data[REQ_MEM] = 64'h2222;
    m_addr[REQ_FPU] = 5'd3;  m_data[REQ_FPU] = 64'h3333;
    for (int n = 0; n < 4; n++) begin
      step(3'b111, 1'b0, 5'd0, g);
      if (g >= 0) begin
        m_data[g] = m_data[g] + 64'h0100_0000;
        m_addr[g] = m_addr[g] + 5'd4;
      end
    end

    // x0 request from the load unit, and an x0 issue
    m_addr[REQ_MEM] = 5'd0;
    m_data[REQ_MEM] = 64'h1234;
    step(3'b010, 1'b1, 5'd0, g);
    m_addr[REQ_MEM] = 5'd12;
    step(3'b111, 1'b0, 5'd0, g);
    step(3'b000, 1'b0, 5'd0, g);

    // Set/clear collision on r7, then a later write clears it
    m_addr[REQ_FPU] = 5'd7;
    m_data[REQ_FPU] = 64'h7777;
    step(3'b100, 1'b0, 5'd0, g);
    step(3'b000, 1'b1, 5'd7, g);
    step(3'b000, 1'b0, 5'd0, g);
    m_addr[REQ_ALU] = 5'd7;
    m_data[REQ_ALU] = 64'h7070;
    step(3'b001, 1'b0, 5'd0, g);
    step(3'b000, 1'b0, 5'd0, g);

    // Reset mid-operation: write to r9 in flight, pointer left at 2
    step(3'b000, 1'b1, 5'd9, g);
    m_addr[REQ_MEM] = 5'd9;
    m_data[REQ_MEM] = 64'h9999;
    step(3'b010, 1'b0, 5'd0, g);
    do_reset();
    m_addr[REQ_ALU] = 5'd10;
    m_addr[REQ_MEM] = 5'd11;
    m_addr[REQ_FPU] = 5'd13;
    step(3'b111, 1'b0, 5'd0, g);
    step(3'b000, 1'b0, 5'd0, g);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_port_scheduler.md
Name: wb_port_scheduler

Overview:
- Shares the integer register file's single write port between NUM_REQ write-back requesters: ALU (0), load unit (1) and FPU-to-integer moves (2).
- Uses round-robin arbitration and drives the register file write port from a one-cycle output register.
- Keeps a per-register busy scoreboard (set at issue, cleared at write commit) that the decode stage uses for RAW/WAW stall decisions.

Parameters:
- DATA_WIDTH, 64, register data width
- ADDR_WIDTH, 5, register address width; scoreboard depth is 2**ADDR_WIDTH
- NUM_REQ, 3, number of write-back requesters

Ports:
- Clk  in  1  clock, rising edge
- Rst  in  1  asynchronous reset, active-high
- req_Valid  in  NUM_REQ  per-requester write request
- req_Addr  in  NUM_REQ*ADDR_WIDTH  destination register; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_Data  in  NUM_REQ*DATA_WIDTH  write data; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH]
- req_Grant  out  NUM_REQ  one-hot grant, combinational
- rf_write_En  out  1  register file write enable, registered
- rf_writeAddr  out  ADDR_WIDTH  register file write address, registered
- rf_data_in  out  DATA_WIDTH  register file write data, registered
- issue_En  in  1  decode issued an instruction that writes a destination register
- issue_Addr  in  ADDR_WIDTH  destination register of the issued instruction
- busy_Vec  out  2**ADDR_WIDTH  scoreboard; bit r = register r has a write pending

Behaviour:
- Reset (async, Rst=1):
  - rr_ptr=0.
  - rf_write_En=0, rf_writeAddr=0, rf_data_in=0.
  - busy_Vec all 0.
  - req_Grant forced 0 while Rst=1.
  - In-flight writes are dropped; requesters re-present after reset.
- Arbitration:
  - Grant goes to the first i with req_Valid[i]=1, searching from rr_ptr upward modulo NUM_REQ.
  - At most one grant per cycle.
  - Zero valid requests -> req_Grant=0.
  - On a grant to index g: rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Handshake:
  - A requester holds Valid, Addr and Data stable until the cycle in which its Grant=1.
  - It may drop Valid, or present a new request, in the following cycle.
  - Grant never depends on any input other than req_Valid and rr_ptr.
- Output stage (latency 1):
  - Grant at cycle t -> at the edge ending cycle t: rf_writeAddr/rf_data_in <= granted Addr/Data, and rf_write_En <= (Addr != 0).
  - The register file commits at the following edge.
  - No grant -> rf_write_En <= 0; rf_writeAddr and rf_data_in hold their previous values.
- x0 handling:
  - A request to register 0 is granted and consumes the slot, but produces no write enable.
  - issue_En with issue_Addr=0 is ignored; busy_Vec[0] is constant 0.
- Scoreboard, evaluated per edge, for each register r != 0:
  - set = issue_En && issue_Addr==r
  - clr = rf_write_En && rf_writeAddr==r
  - busy[r] <= set ? 1 : (clr ? 0 : busy[r])
  - Set wins over a simultaneous clear to the same register, because a new producer was issued.
  - busy clears on the same edge that the register file commits the data. Readers in the next cycle therefore see busy=0 and the new value together.
- Issue to an already-busy register is illegal (decode must stall on WAW). The bit stays 1, and the bench flags it with an assertion.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles.

Decomposition:
- Shared package holds:
  - REQ_ALU=0, REQ_MEM=1, REQ_FPU=2
  - NUM_WB_REQ=3
  - XLEN=64, REG_ADDR_W=5
- Natural sub-module: rr_arbiter, parameterised on N.
  - Inputs: valid vector and clock/reset.
  - Outputs: one-hot grant and encoded index.
  - Owns rr_ptr.
- Output register and scoreboard stay in wb_port_scheduler.

Test Plan:
- Reset then idle: Rst pulse mid-cycle -> all outputs 0 immediately (async); req_Valid=0 for 10 cycles -> rf_write_En stays 0.
- Single write: issue_En addr=5; next cycle req_Valid=001, Addr0=5, Data0=0xDEAD_BEEF -> Grant=001 same cycle; next cycle rf_write_En=1, addr 5, data 0xDEADBEEF; busy_Vec[5] 1 -> 0 one edge later.
- Contention: all three Valid held continuously, rr_ptr=0 -> grants 001, 010, 100, 001 on consecutive cycles; each requester updates its data after its grant; rf writes appear in the same order, one cycle later.
- x0 request: req_Valid=010, Addr1=0, Data1=0x1234 -> Grant=010; rf_write_En stays 0; rr_ptr advances to 2; issue_En addr=0 -> busy_Vec[0]=0.
- Set/clear collision: rf_write_En=1 to reg 7 on the same edge as issue_En addr=7 -> busy_Vec[7]=1 afterwards; a separate write to reg 7 later clears it.
- Reset mid-operation: grant to reg 9 at cycle t, Rst asserted in cycle t+1 before commit -> rf_write_En=0, busy_Vec all 0, rr_ptr=0; after release, first valid at index 0 wins.
